// File: rtl/mem_arb_pkg.sv
// Shared encodings and request payload for the icache/LSB memory arbiter.
package mem_arb_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned LS_TYPE_W    = 3;
  localparam int unsigned STARVE_CNT_W = 4;

  localparam logic [LS_TYPE_W-1:0] LS_W  = 3'b000;
  localparam logic [LS_TYPE_W-1:0] LS_HU = 3'b001;
  localparam logic [LS_TYPE_W-1:0] LS_BU = 3'b010;
  localparam logic [LS_TYPE_W-1:0] LS_H  = 3'b101;
  localparam logic [LS_TYPE_W-1:0] LS_B  = 3'b110;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_LSB  = 2'b01,
    OWN_IC   = 2'b10
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      wdata;
    logic                 r_nw;
    logic [LS_TYPE_W-1:0] ls_type;
  } mc_req_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of LSB grants taken while the icache was waiting.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic en,
  input  logic inc,
  input  logic clr,
  output logic at_limit_c
);

  logic [STARVE_CNT_W-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt <= '0;
    end else if (en) begin
      if (clr) begin
        cnt <= '0;
      end else if (inc && (cnt < STARVE_CNT_W'(STARVE_LIMIT))) begin
        cnt <= cnt + STARVE_CNT_W'(1);
      end
    end
  end

  assign at_limit_c = (cnt >= STARVE_CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Icache/LSB arbiter in front of the byte-serial memory controller.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 ic_req,
  input  logic [XLEN-1:0]      ic_addr,
  output logic                 ic_accept,
  output logic                 ic_valid,
  output logic [XLEN-1:0]      ic_rdata,
  input  logic                 lsb_req,
  input  logic [XLEN-1:0]      lsb_addr,
  input  logic [XLEN-1:0]      lsb_wdata,
  input  logic                 lsb_r_nw,
  input  logic [LS_TYPE_W-1:0] lsb_type,
  output logic                 lsb_accept,
  output logic                 lsb_valid,
  output logic [XLEN-1:0]      lsb_rdata,
  output logic                 mc_activate,
  output logic [XLEN-1:0]      mc_addr,
  output logic [XLEN-1:0]      mc_wdata,
  output logic                 mc_r_nw,
  output logic [LS_TYPE_W-1:0] mc_type,
  input  logic [XLEN-1:0]      mc_rdata,
  input  logic                 mc_done,
  output logic [CNT_W-1:0]     perf_ic_grants,
  output logic [CNT_W-1:0]     perf_lsb_grants,
  output logic [CNT_W-1:0]     perf_stall_cyc
);

  localparam mc_req_t REQ_RESET = '{addr: '0, wdata: '0, r_nw: 1'b1, ls_type: LS_W};

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              drop_q, drop_d;
  mc_req_t           req_q, req_d;
  logic              act_q, act_d;
  logic              ic_acc_q, ic_acc_d, ic_val_q, ic_val_d;
  logic              lsb_acc_q, lsb_acc_d, lsb_val_q, lsb_val_d;
  logic [XLEN-1:0]   ic_rd_q, ic_rd_d, lsb_rd_q, lsb_rd_d;
  logic              force_ic_c, grant_ic_c, grant_lsb_c, droppable_c, drop_now_c;

  // LSB wins unless the icache has been starved; a flush blocks icache grants.
  assign grant_ic_c  = (state_q == ST_IDLE) && ic_req && !flush_in && (!lsb_req || force_ic_c);
  assign grant_lsb_c = (state_q == ST_IDLE) && lsb_req && !grant_ic_c;
  assign droppable_c = (owner_q == OWN_IC) || ((owner_q == OWN_LSB) && req_q.r_nw);
  assign drop_now_c  = drop_q || (flush_in && droppable_c);

  mem_arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .en         (rdy_in),
    .inc        (grant_lsb_c && ic_req),
    .clr        (grant_ic_c || (grant_lsb_c && !ic_req)),
    .at_limit_c (force_ic_c)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_NONE;
      drop_q    <= 1'b0;
      req_q     <= REQ_RESET;
      act_q     <= 1'b0;
      ic_acc_q  <= 1'b0;
      ic_val_q  <= 1'b0;
      lsb_acc_q <= 1'b0;
      lsb_val_q <= 1'b0;
      ic_rd_q   <= '0;
      lsb_rd_q  <= '0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      drop_q    <= drop_d;
      req_q     <= req_d;
      act_q     <= act_d;
      ic_acc_q  <= ic_acc_d;
      ic_val_q  <= ic_val_d;
      lsb_acc_q <= lsb_acc_d;
      lsb_val_q <= lsb_val_d;
      ic_rd_q   <= ic_rd_d;
      lsb_rd_q  <= lsb_rd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    drop_d    = drop_q;
    req_d     = req_q;
    act_d     = act_q;
    ic_acc_d  = 1'b0;
    ic_val_d  = 1'b0;
    lsb_acc_d = 1'b0;
    lsb_val_d = 1'b0;
    ic_rd_d   = ic_rd_q;
    lsb_rd_d  = lsb_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_ic_c) begin
          req_d    = '{addr: ic_addr, wdata: '0, r_nw: 1'b1, ls_type: LS_W};
          act_d    = 1'b1;
          ic_acc_d = 1'b1;
          owner_d  = OWN_IC;
          state_d  = ST_BUSY;
        end else if (grant_lsb_c) begin
          req_d     = '{addr: lsb_addr, wdata: lsb_wdata, r_nw: lsb_r_nw, ls_type: lsb_type};
          act_d     = 1'b1;
          lsb_acc_d = 1'b1;
          owner_d   = OWN_LSB;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (flush_in && droppable_c) drop_d = 1'b1;
        if (mc_done) begin
          act_d      = 1'b0;
          req_d.r_nw = 1'b1;
          state_d    = ST_DRAIN;
          if (!drop_now_c) begin
            if (owner_q == OWN_IC) begin
              ic_val_d = 1'b1;
              ic_rd_d  = mc_rdata;
            end else if (owner_q == OWN_LSB) begin
              lsb_val_d = 1'b1;
              lsb_rd_d  = req_q.r_nw ? mc_rdata : '0;
            end
          end
        end
      end
      ST_DRAIN: begin
        drop_d  = 1'b0;
        owner_d = OWN_NONE;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ic_accept   = ic_acc_q;
  assign ic_valid    = ic_val_q;
  assign ic_rdata    = ic_rd_q;
  assign lsb_accept  = lsb_acc_q;
  assign lsb_valid   = lsb_val_q;
  assign lsb_rdata   = lsb_rd_q;
  assign mc_activate = act_q;
  assign mc_addr     = req_q.addr;
  assign mc_wdata    = req_q.wdata;
  assign mc_r_nw     = req_q.r_nw;
  assign mc_type     = req_q.ls_type;

`ifdef MEM_ARB_PERF_EN
  logic [CNT_W-1:0] perf_ic_q, perf_lsb_q, perf_stall_q;
  logic             stall_c;

  assign stall_c = (ic_req || lsb_req) && !(grant_ic_c || grant_lsb_c);

  // Saturating event counters, frozen with the rest of the arbiter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_ic_q    <= '0;
      perf_lsb_q   <= '0;
      perf_stall_q <= '0;
    end else if (rdy_in) begin
      if (grant_ic_c && (perf_ic_q != '1))     perf_ic_q    <= perf_ic_q + CNT_W'(1);
      if (grant_lsb_c && (perf_lsb_q != '1))   perf_lsb_q   <= perf_lsb_q + CNT_W'(1);
      if (stall_c && (perf_stall_q != '1))     perf_stall_q <= perf_stall_q + CNT_W'(1);
    end
  end

  assign perf_ic_grants  = perf_ic_q;
  assign perf_lsb_grants = perf_lsb_q;
  assign perf_stall_cyc  = perf_stall_q;
`else
  assign perf_ic_grants  = '0;
  assign perf_lsb_grants = '0;
  assign perf_stall_cyc  = '0;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates between the instruction cache and the load/store buffer (LSB) for the single byte-serial memory controller.
- Latches one request per cycle and holds a single-channel request to the controller until data_available.
- Routes the result back to the owner.
- Gives LSB priority with a starvation guard for icache, and handles pipeline flush on mispredict.

Parameters:
- STARVE_LIMIT, 4: consecutive LSB grants while icache waits before icache is forced next (1..15).
- CNT_W, 32: width of performance counters (Optional Feature only).

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; low freezes all state
- flush_in  in  1  mispredict flush
- ic_req  in  1  icache fetch request (word read)
- ic_addr  in  32  fetch address
- ic_accept  out  1  1-cycle pulse: icache request latched
- ic_valid  out  1  1-cycle pulse: ic_rdata valid
- ic_rdata  out  32  fetched word
- lsb_req  in  1  LSB request
- lsb_addr  in  32  LSB address
- lsb_wdata  in  32  store data
- lsb_r_nw  in  1  1 read, 0 write
- lsb_type  in  3  000 W, 001 HU, 010 BU, 101 H, 110 B
- lsb_accept  out  1  1-cycle pulse: LSB request latched
- lsb_valid  out  1  1-cycle pulse: load data valid or store done
- lsb_rdata  out  32  load result (0 for stores)
- mc_activate  out  1  request to controller, held until mc_done
- mc_addr  out  32  request address
- mc_wdata  out  32  request store data
- mc_r_nw  out  1  request direction
- mc_type  out  3  request type
- mc_rdata  in  32  controller data_out
- mc_done  in  1  controller data_available
- perf_ic_grants  out  CNT_W  icache grants
- perf_lsb_grants  out  CNT_W  LSB grants
- perf_stall_cyc  out  CNT_W  cycles any requester waited

Behaviour:
- Reset: all outputs 0; mc_r_nw = 1; state IDLE; starve counter 0; drop flag 0.
- rdy_in low: no state changes and no pulses; outputs hold.
- States: IDLE, BUSY, DRAIN.
- IDLE grant choice among pending requesters:
  - LSB, unless starve_cnt >= STARVE_LIMIT and ic_req is high; then icache.
  - If only one requester is pending, it is granted.
  - A flush_in cycle suppresses any icache grant.
- On grant, same edge:
  - Register mc_* fields and raise mc_activate.
  - Pulse the matching *_accept for one cycle.
  - Go to BUSY.
  - Record owner (01 LSB, 10 icache).
- Icache requests are always issued as mc_r_nw = 1, mc_type = 000.
- starve_cnt:
  - Increments, saturating, on an LSB grant while ic_req is high.
  - Clears on an icache grant, or when ic_req is low at a grant.
- BUSY: mc_* held stable. When mc_done is sampled high:
  - Drop mc_activate and restore mc_r_nw = 1.
  - Pulse the owner's *_valid with data mc_rdata; LSB stores return lsb_rdata = 0.
  - Go to DRAIN.
- DRAIN: one idle cycle so the controller returns to its free state, then IDLE.
  - Minimum spacing is issue, done, drain, next issue.
  - Latency: request latched at edge N; mc_activate is visible from cycle N+1.
- Flush:
  - In IDLE: pending ic_req is ignored that cycle.
  - In BUSY with an icache owner or an LSB load owner: set the drop flag; the transaction finishes on the bus, but no *_valid is raised.
  - LSB stores are never dropped; lsb_valid is still raised.
  - The drop flag clears in DRAIN.
- Simultaneous mc_done and flush_in: the flush wins; the response is dropped unless the owner is a store.
- Requesters must hold req, addr and data until *_accept; a req deasserted before accept is simply not granted.
- Reset mid-transaction: the arbiter returns to IDLE immediately. The controller is reset by the same rst_in, so no cleanup handshake is needed.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined: three saturating counters of CNT_W bits.
  - perf_ic_grants and perf_lsb_grants increment on each grant.
  - perf_stall_cyc increments on each rdy_in cycle where ic_req or lsb_req is high and no accept pulse occurs.
  - All counters clear on reset.
- Undefined: the perf_* ports remain and are tied to 0; no counter flops are synthesised.

Decomposition:
- Shared package/macros header:
  - LS type encodings (000/001/010/101/110).
  - Owner encodings (00 none, 01 LSB, 10 icache).
  - State encodings IDLE/BUSY/DRAIN.
- One sub-module, mem_arb_starve_ctr: saturating counter with inc/clr/limit-compare output, parameterised by STARVE_LIMIT.

Test Plan:
- Single icache fetch at 0x1000, controller returns 0x00C0FFEE after 4 cycles:
  - ic_accept pulses once.
  - mc_activate high until mc_done.
  - ic_valid with ic_rdata = 0x00C0FFEE.
  - 1 DRAIN cycle, then IDLE.
- ic_req and lsb_req (LW 0x2000) asserted together: LSB granted first; icache granted immediately after the DRAIN cycle.
- lsb_req held high for 6 back-to-back loads with ic_req high, STARVE_LIMIT = 4: icache granted after exactly 4 LSB grants; starve counter then clears.
- Flush during icache BUSY: mc transaction completes, no ic_valid pulse; the next ic_req issued 2 cycles later is granted normally.
- Flush during LSB SB to 0x30000 with data 0x41: mc_wdata = 0x41 held until done; lsb_valid still pulses with lsb_rdata = 0.
- rdy_in low for 3 cycles mid-BUSY, then rst_in asserted mid-BUSY: all outputs frozen while rdy_in is low; after reset, all outputs 0 and state IDLE; with MEM_ARB_PERF_EN defined, counters read 0.
